// File: rtl/bn_channel_sequencer.sv
// Per-channel batch-norm sequencer: fetches (delta, mu, beta) for each channel, then streams
// that channel's samples through the external combinational datapath into a tagged output register.
module bn_channel_sequencer #(
    parameter int W1    = 24,
    parameter int W2    = 18,
    parameter int W4    = 9,
    parameter int CH_W  = 6,
    parameter int PIX_W = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic        [CH_W-1:0]  num_ch,
    input  logic        [PIX_W-1:0] num_pix,
    output logic                    busy,
    output logic                    done,
    output logic                    prm_rd_en,
    output logic        [CH_W-1:0]  prm_addr,
    input  logic signed [W2-1:0]    prm_delta,
    input  logic signed [W2-1:0]    prm_mu,
    input  logic signed [W2-1:0]    prm_beta,
    input  logic                    in_valid,
    input  logic signed [W1-1:0]    in_data,
    output logic                    in_ready,
    output logic signed [W1-1:0]    bn_din,
    output logic signed [W2-1:0]    bn_delta,
    output logic signed [W2-1:0]    bn_mu,
    output logic signed [W2-1:0]    bn_beta,
    input  logic signed [W4-1:0]    bn_oup,
    output logic                    out_valid,
    output logic        [W4-1:0]    out_data,
    output logic        [CH_W-1:0]  out_ch,
    output logic                    out_last,
    input  logic                    out_ready
);

    typedef enum logic [2:0] {IDLE, PREQ, PWAIT, STREAM, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [CH_W-1:0]         num_ch_q, num_ch_d;
    logic [PIX_W-1:0]        num_pix_q, num_pix_d;
    logic [CH_W-1:0]         ch_cnt_q, ch_cnt_d;
    logic [PIX_W-1:0]        pix_cnt_q, pix_cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    prm_rd_en_q, prm_rd_en_d;
    logic signed [W2-1:0]    delta_q, delta_d;
    logic signed [W2-1:0]    mu_q, mu_d;
    logic signed [W2-1:0]    beta_q, beta_d;
    logic                    out_valid_q, out_valid_d;
    logic [W4-1:0]           out_data_q, out_data_d;
    logic [CH_W-1:0]         out_ch_q, out_ch_d;
    logic                    out_last_q, out_last_d;

    logic accept;
    logic last_pix;
    logic last_ch;

    // A sample may enter whenever the output register is empty or being emptied this cycle.
    assign in_ready = (state_q == STREAM) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign last_pix = (pix_cnt_q == num_pix_q - PIX_W'(1));
    assign last_ch  = (ch_cnt_q == num_ch_q - CH_W'(1));

    assign busy      = busy_q;
    assign done      = done_q;
    assign prm_rd_en = prm_rd_en_q;
    assign prm_addr  = ch_cnt_q;
    assign bn_din    = in_data;
    assign bn_delta  = delta_q;
    assign bn_mu     = mu_q;
    assign bn_beta   = beta_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;

    always_comb begin
        state_d     = state_q;
        num_ch_d    = num_ch_q;
        num_pix_d   = num_pix_q;
        ch_cnt_d    = ch_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        prm_rd_en_d = 1'b0;
        delta_d     = delta_q;
        mu_d        = mu_q;
        beta_d      = beta_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = bn_oup;
            out_ch_d    = ch_cnt_q;
            out_last_d  = last_pix && last_ch;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d = 1'b1;
                    // A zero-sized run completes immediately without touching memory.
                    if (num_ch != '0 && num_pix != '0) begin
                        num_ch_d    = num_ch;
                        num_pix_d   = num_pix;
                        ch_cnt_d    = '0;
                        pix_cnt_d   = '0;
                        prm_rd_en_d = 1'b1;
                        state_d     = PREQ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            PREQ: begin
                state_d = PWAIT;
            end
            PWAIT: begin
                delta_d = prm_delta;
                mu_d    = prm_mu;
                beta_d  = prm_beta;
                state_d = STREAM;
            end
            STREAM: begin
                if (accept) begin
                    if (last_pix) begin
                        pix_cnt_d = '0;
                        if (last_ch) begin
                            state_d = DRAIN;
                        end else begin
                            ch_cnt_d    = ch_cnt_q + CH_W'(1);
                            prm_rd_en_d = 1'b1;
                            state_d     = PREQ;
                        end
                    end else begin
                        pix_cnt_d = pix_cnt_q + PIX_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (!out_valid_q || out_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            num_ch_q    <= '0;
            num_pix_q   <= '0;
            ch_cnt_q    <= '0;
            pix_cnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            prm_rd_en_q <= 1'b0;
            delta_q     <= '0;
            mu_q        <= '0;
            beta_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_ch_q    <= num_ch_d;
            num_pix_q   <= num_pix_d;
            ch_cnt_q    <= ch_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            prm_rd_en_q <= prm_rd_en_d;
            delta_q     <= delta_d;
            mu_q        <= mu_d;
            beta_q      <= beta_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule
